uart_tx_feeder: RTL and testbench

//  - Byte FIFO plus launch FSM directly upstream of the UART Top transmit port.
//  - Accepts bytes on a valid/ready stream and buffers up to DEPTH of them.
//  - Drives TX_data/transmit with the UART handshake: raise transmit, drop it when busy is seen high, wait for busy low.
//  - Removes per-byte software handshaking from the host side.

---
 rtl/uart_tx_feeder.sv | 102 ++++++++++
 tb/tb_uart_tx_feeder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO and launch FSM driving a UART transmit port.
// Optional launch timeout is enabled by defining UART_FEEDER_TIMEOUT_EN.
module uart_tx_feeder #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      TX_data,
  output logic                       transmit,
  input  logic                       busy,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       launch_error
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic                  push, pop, transmit_n, tmo;

  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign in_ready = !full;
  assign push     = in_valid && in_ready;

`ifdef UART_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;
  assign tmo = state == LAUNCH && !busy && tcnt == TW'(TIMEOUT_CYCLES - 1);
  // Launch watchdog: counts busy-low cycles since entering LAUNCH
  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt         <= '0;
      launch_error <= 1'b0;
    end else begin
      tcnt         <= state == LAUNCH ? tcnt + 1'b1 : '0;
      launch_error <= tmo;
    end
  end
`else
  assign tmo          = 1'b0;
  assign launch_error = 1'b0;
`endif

  // Next-state and pop decision for the UART handshake
  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    transmit_n = transmit;
    if (state == IDLE && !empty && !busy) begin
      pop        = 1'b1;
      transmit_n = 1'b1;
      state_n    = LAUNCH;
    end else if (state == LAUNCH && busy) begin
      transmit_n = 1'b0;
      state_n    = WAIT_DONE;
    end else if (tmo) begin
      transmit_n = 1'b0;
      state_n    = IDLE;
    end else if (state == WAIT_DONE && !busy) begin
      state_n    = IDLE;
    end
  end

  // Storage array; not reset, contents are only meaningful between pointers
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  // State, pointers, occupancy and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      TX_data  <= '0;
      transmit <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      transmit <= transmit_n;
      overflow <= in_valid && !in_ready;
      count    <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        TX_data <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed bench with a queue-based reference model checked every cycle.
module tb_uart_tx_feeder;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int FRAME   = 10;
`ifdef UART_FEEDER_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk, rst, in_valid, in_ready, transmit, busy, full, empty, overflow, launch_error;
  logic [7:0] in_data, TX_data;
  logic [4:0] count;
  logic       auto, busy_man, uart_busy, chk_en;
  int         errors = 0, checks = 0;

  uart_tx_feeder dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .TX_data(TX_data), .transmit(transmit), .busy(busy), .count(count), .full(full),
    .empty(empty), .overflow(overflow), .launch_error(launch_error)
  );

  assign busy = auto ? uart_busy : busy_man;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: byte queue plus handshake bookkeeping, evaluated on the same edge as the DUT
  logic [7:0] q[$];
  logic [7:0] m_tx = 0;
  bit         m_transmit = 0, m_draining = 0, m_ov = 0, m_err = 0;
  int         m_tc = 0;

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      m_tx = 0; m_transmit = 0; m_draining = 0; m_ov = 0; m_err = 0; m_tc = 0;
    end else begin
      bit do_push;
      do_push = in_valid && q.size() < DEPTH;
      m_ov    = in_valid && q.size() == DEPTH;
      m_err   = 0;
      if (m_transmit) begin
        if (busy) begin
          m_transmit = 0;
          m_draining = 1;
        end else begin
          m_tc++;
          if (TMO && m_tc == TIMEOUT) begin
            m_transmit = 0;
            m_err = 1;
          end
        end
      end else if (m_draining) begin
        if (!busy) m_draining = 0;
      end else if (q.size() > 0 && !busy) begin
        m_tx = q.pop_front();
        m_transmit = 1;
        m_tc = 0;
      end
      if (do_push) q.push_back(in_data);
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(q.size()));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      check("transmit", 32'(transmit), 32'(m_transmit));
      check("TX_data", 32'(TX_data), 32'(m_tx));
      check("overflow", 32'(overflow), 32'(m_ov));
      check("launch_error", 32'(launch_error), 32'(m_err));
    end
  end

  // Simple UART stand-in: captures the byte at launch, goes busy for a frame
  logic [7:0] rx[$];
  int         pend = 0, ub_cnt = 0;
  always @(negedge clk) begin
    if (auto) begin
      if (ub_cnt > 0) begin
        ub_cnt--;
        if (ub_cnt == 0) uart_busy = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          uart_busy = 1;
          ub_cnt = FRAME;
        end
      end else if (transmit && !uart_busy) begin
        rx.push_back(TX_data);
        pend = 2;
      end
    end
  end

  task automatic push_byte(input logic [7:0] d);
    in_valid = 1;
    in_data  = d;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 3000 && rx.size() < n; i++) @(negedge clk);
    check("rx_count", 32'(rx.size()), 32'(n));
  endtask

  logic [7:0] burst[5] = '{8'h55, 8'hA5, 8'hFF, 8'h00, 8'h3C};

  initial begin
    bit seen_tx;
    int base;
    rst = 0; in_valid = 0; in_data = 0; auto = 1; busy_man = 0; uart_busy = 0; chk_en = 0;
    repeat (5) @(negedge clk);
    chk_en = 1;
    check("rst_transmit", 32'(transmit), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst = 1;
    @(negedge clk);

    // single byte, idle UART
    push_byte(8'h55);
    @(negedge clk);
    check("single_transmit", 32'(transmit), 1);
    check("single_data", 32'(TX_data), 32'h55);
    for (int i = 0; i < 50 && !busy; i++) @(posedge clk);
    @(negedge clk);
    check("drop_after_busy", 32'(transmit), 0);
    wait_rx(1);
    check("single_rx", 32'(rx[0]), 32'h55);
    repeat (FRAME + 5) @(negedge clk);

    // burst with the UART held by another source, then released
    auto = 0; busy_man = 1;
    foreach (burst[i]) push_byte(burst[i]);
    check("burst_peak", 32'(count), 5);
    auto = 1;
    wait_rx(6);
    check("burst_empty", 32'(empty), 1);
    for (int i = 0; i < 5; i++) check("burst_order", 32'(rx[1+i]), 32'(burst[i]));
    repeat (FRAME + 5) @(negedge clk);

    // fill to DEPTH, then one overflow
    auto = 0; busy_man = 1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i * 7 + 3));
    check("fill_full", 32'(full), 1);
    check("fill_in_ready", 32'(in_ready), 0);
    check("fill_count", 32'(count), 16);
    push_byte(8'hEE);
    check("overflow_pulse", 32'(overflow), 1);
    check("overflow_count", 32'(count), 16);
    @(negedge clk);
    check("overflow_clear", 32'(overflow), 0);
    auto = 1;
    base = rx.size();
    wait_rx(base + DEPTH);
    for (int i = 0; i < DEPTH; i++) check("fill_order", 32'(rx[base+i]), 32'(8'(i * 7 + 3)));
    repeat (FRAME + 5) @(negedge clk);

    // reset while waiting for the frame to finish, three bytes queued
    auto = 0; busy_man = 0;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    check("pre_rst_count", 32'(count), 3);
    check("pre_rst_transmit", 32'(transmit), 1);
    busy_man = 1;
    @(negedge clk);
    check("wait_done_transmit", 32'(transmit), 0);
    rst = 0;
    @(negedge clk);
    rst = 1;
    check("mid_rst_transmit", 32'(transmit), 0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_empty", 32'(empty), 1);
    repeat (5) @(negedge clk);
    busy_man = 0;
    seen_tx = 0;
    repeat (20) begin
      @(negedge clk);
      seen_tx |= transmit;
    end
    check("no_launch_after_rst", 32'(seen_tx), 0);

    // launch timeout with busy stuck low
    push_byte(8'hA5);
    @(negedge clk);
    check("to_transmit_rise", 32'(transmit), 1);
    repeat (TIMEOUT) @(negedge clk);
    check("to_error", 32'(launch_error), 32'(TMO));
    check("to_transmit", 32'(transmit), 32'(!TMO));
    check("to_empty", 32'(empty), 1);
    @(negedge clk);
    check("to_error_clear", 32'(launch_error), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
